// File: rtl/plic_mem_arbiter.sv
// plic_mem_arbiter
// Shares one single-port memory between NUM_REQ request front ends.
// Each front end sends a one-cycle csb pulse. The pulse is buffered per requester.
// Requests are then served round-robin with one memory access outstanding at a time.
// Optional feature macro: PLIC_ARB_TIMEOUT_EN adds a WAIT-state watchdog that gives up
// after TIMEOUT_CYC cycles and answers with err=1, rdata=0.

module plic_mem_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int DOMAIN_W       = 1,
    parameter int TIMEOUT_CYC    = 256
) (
    input  logic                               pclk_i,
    input  logic                               prst_n_i,
    input  logic [NUM_REQ-1:0]                 req_csb_i,
    input  logic [NUM_REQ-1:0]                 req_rwb_i,
    input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    req_wm_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata_i,
    input  logic [NUM_REQ-1:0]                 req_pri_i,
    input  logic [NUM_REQ-1:0]                 req_sec_i,
    input  logic [NUM_REQ-1:0]                 req_data_i,
    input  logic [NUM_REQ*DOMAIN_W-1:0]        req_did_i,
    output logic [NUM_REQ-1:0]                 req_rdy_o,
    output logic [NUM_REQ-1:0]                 req_err_o,
    output logic [NUM_REQ*DATA_WIDTH-1:0]      req_rdata_o,
    output logic                               mem_csb_o,
    output logic                               mem_rwb_o,
    output logic [MEM_ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]            mem_wm_o,
    output logic [DATA_WIDTH-1:0]              mem_wdata_o,
    output logic                               mem_pri_o,
    output logic                               mem_sec_o,
    output logic                               mem_data_o,
    output logic [DOMAIN_W-1:0]                mem_did_o,
    input  logic                               mem_rdy_i,
    input  logic                               mem_err_i,
    input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
    output logic                               arb_busy_o,
    output logic [$clog2(NUM_REQ)-1:0]         arb_gnt_o
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int MAW = MEM_ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int MW  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    pend_q, pend_d;
    logic [GW-1:0]         gnt_q, gnt_d;
    logic [GW-1:0]         lastGnt_q, lastGnt_d;
    logic [DW-1:0]         respData_q, respData_d;
    logic                  respErr_q, respErr_d;

    logic [NUM_REQ-1:0]    bufRwb_q, bufPri_q, bufSec_q, bufData_q;
    logic [MAW-1:0]        bufAddr_q  [NUM_REQ];
    logic [MW-1:0]         bufWm_q    [NUM_REQ];
    logic [DW-1:0]         bufWdata_q [NUM_REQ];
    logic [DOMAIN_W-1:0]   bufDid_q   [NUM_REQ];

    logic [NUM_REQ-1:0]    capture;
    logic [GW-1:0]         win;
    logic                  winValid;
    logic [GW-1:0]         sel;
    logic                  memDrive;
    logic                  tmrExpired;

    // A pulse is only accepted from a requester that has nothing queued yet.
    assign capture = ~req_csb_i & ~pend_q;

`ifdef PLIC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmr_q, tmr_d;

    // The watchdog counts WAIT cycles and restarts from zero on every WAIT entry.
    always_comb begin
        tmr_d = '0;
        if (state_q == ST_WAIT) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    // The last allowed WAIT cycle is the one where the count reads TIMEOUT_CYC-1.
    assign tmrExpired = (tmr_q == TW'(TIMEOUT_CYC - 1));
`else
    // The watchdog is not built, so WAIT only leaves on mem_rdy_i. This compare is constant false.
    assign tmrExpired = (TIMEOUT_CYC < 0);
`endif

    // Round-robin pick: scan from lastGnt+1 upward and let the nearest pending requester win.
    always_comb begin
        logic [GW-1:0] cand;
        win      = lastGnt_q;
        winValid = 1'b0;
        cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = GW'((int'(lastGnt_q) + i) % NUM_REQ);
            if (pend_q[cand]) begin
                win      = cand;
                winValid = 1'b1;
            end
        end
    end

    // Per-requester request buffers. They load only when the pulse is accepted.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            bufRwb_q  <= '0;
            bufPri_q  <= '0;
            bufSec_q  <= '0;
            bufData_q <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                bufAddr_q[k]  <= '0;
                bufWm_q[k]    <= '0;
                bufWdata_q[k] <= '0;
                bufDid_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (capture[k]) begin
                    bufRwb_q[k]   <= req_rwb_i[k];
                    bufPri_q[k]   <= req_pri_i[k];
                    bufSec_q[k]   <= req_sec_i[k];
                    bufData_q[k]  <= req_data_i[k];
                    bufAddr_q[k]  <= req_addr_i[k*MAW +: MAW];
                    bufWm_q[k]    <= req_wm_i[k*MW +: MW];
                    bufWdata_q[k] <= req_wdata_i[k*DW +: DW];
                    bufDid_q[k]   <= req_did_i[k*DOMAIN_W +: DOMAIN_W];
                end
            end
        end
    end

    // Arbiter next-state logic. Pending bits set on capture and clear in RESP.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q | capture;
        gnt_d      = gnt_q;
        lastGnt_d  = lastGnt_q;
        respData_d = respData_q;
        respErr_d  = respErr_q;
        case (state_q)
            ST_IDLE: begin
                if (winValid) begin
                    gnt_d     = win;
                    lastGnt_d = win;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rdy_i) begin
                    respData_d = mem_rdata_i;
                    respErr_d  = mem_err_i;
                    state_d    = ST_RESP;
                end else if (tmrExpired) begin
                    respData_d = '0;
                    respErr_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                pend_d[gnt_q] = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers. lastGnt resets to the top index so requester 0 wins first.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            gnt_q      <= '0;
            lastGnt_q  <= GW'(NUM_REQ - 1);
            respData_q <= '0;
            respErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            gnt_q      <= gnt_d;
            lastGnt_q  <= lastGnt_d;
            respData_q <= respData_d;
            respErr_q  <= respErr_d;
        end
    end

    // Memory-side mux. It shows the winner during the IDLE grant cycle and the owner afterwards.
    // When nothing is pending in IDLE, the memory side is driven to zero.
    always_comb begin
        sel       = (state_q == ST_IDLE) ? win : gnt_q;
        memDrive  = (state_q != ST_IDLE) || winValid;
        mem_csb_o = ~((state_q == ST_IDLE) && winValid);
        mem_rwb_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wm_o    = '0;
        mem_wdata_o = '0;
        mem_pri_o   = 1'b0;
        mem_sec_o   = 1'b0;
        mem_data_o  = 1'b0;
        mem_did_o   = '0;
        if (memDrive) begin
            mem_rwb_o   = bufRwb_q[sel];
            mem_addr_o  = bufAddr_q[sel];
            mem_wm_o    = bufWm_q[sel];
            mem_wdata_o = bufWdata_q[sel];
            mem_pri_o   = bufPri_q[sel];
            mem_sec_o   = bufSec_q[sel];
            mem_data_o  = bufData_q[sel];
            mem_did_o   = bufDid_q[sel];
        end
    end

    // Requester-side responses. Only the owner sees data and error, and only during RESP.
    always_comb begin
        req_rdy_o   = '0;
        req_err_o   = '0;
        req_rdata_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_rdy_o[k] = ~pend_q[k];
            if ((state_q == ST_RESP) && (gnt_q == GW'(k))) begin
                req_rdy_o[k]              = 1'b1;
                req_err_o[k]              = respErr_q;
                req_rdata_o[k*DW +: DW]   = respData_q;
            end
        end
    end

    assign arb_busy_o = (state_q != ST_IDLE);
    assign arb_gnt_o  = gnt_q;

endmodule
